// File: rtl/adder_accum_stage.sv
// rtl/adder_accum_stage.sv - per-packet accumulator for 4-bit prefix adder results
// Optional clamp-on-overflow build: define ADDER_ACCUM_SAT_EN.
module adder_accum_stage #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic             out_valid_n;
  logic [ACC_W-1:0] out_sum_n;
  logic [CNT_W-1:0] out_count_n;
  logic             out_ovf_n;

  logic [ACC_W:0]   beat_v;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_inc;
  logic             in_fire;
  logic             out_fire;

  assign in_ready = !rst && (state != HOLD);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign beat_v  = {{(ACC_W-4){1'b0}}, in_cout, in_sum};
  assign sum_ext = {1'b0, acc} + beat_v;
  assign ovf_inc = ovf | sum_ext[ACC_W];
  // Beat count pins at all-ones instead of wrapping; the sum keeps accumulating.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ADDER_ACCUM_SAT_EN
  assign acc_inc = (sum_ext[ACC_W] || ovf) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_inc = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    ovf_n       = ovf;
    out_valid_n = out_valid;
    out_sum_n   = out_sum;
    out_count_n = out_count;
    out_ovf_n   = out_ovf;

    case (state)
      IDLE: begin
        if (in_fire) begin
          if (in_last) begin
            out_sum_n   = beat_v[ACC_W-1:0];
            out_count_n = {{(CNT_W-1){1'b0}}, 1'b1};
            out_ovf_n   = 1'b0;
            out_valid_n = 1'b1;
            state_n     = HOLD;
          end else begin
            acc_n   = beat_v[ACC_W-1:0];
            cnt_n   = {{(CNT_W-1){1'b0}}, 1'b1};
            ovf_n   = 1'b0;
            state_n = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (in_fire) begin
          if (in_last) begin
            out_sum_n   = acc_inc;
            out_count_n = cnt_inc;
            out_ovf_n   = ovf_inc;
            out_valid_n = 1'b1;
            state_n     = HOLD;
          end else begin
            acc_n = acc_inc;
            cnt_n = cnt_inc;
            ovf_n = ovf_inc;
          end
        end
      end

      HOLD: begin
        // Result registers are left as-is after hand-off; only the running state clears.
        if (out_fire) begin
          out_valid_n = 1'b0;
          acc_n       = '0;
          cnt_n       = '0;
          ovf_n       = 1'b0;
          state_n     = IDLE;
        end
      end

      default: begin
        state_n     = IDLE;
        out_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      ovf       <= ovf_n;
      out_valid <= out_valid_n;
      out_sum   <= out_sum_n;
      out_count <= out_count_n;
      out_ovf   <= out_ovf_n;
    end
  end

endmodule

// File: tb/tb_adder_accum_stage.sv
// tb/tb_adder_accum_stage.sv - self-checking bench for adder_accum_stage
// Drives a default instance and an ACC_W=6/CNT_W=2 instance from the same stimulus.
module tb_adder_accum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_sum;
  logic        in_cout;
  logic        in_last;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [11:0] a_out_sum;
  logic [7:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [5:0]  b_out_sum;
  logic [1:0]  b_out_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_accum_stage #(.ACC_W(12), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
    .out_count(a_out_count), .out_ovf(a_out_ovf)
  );

  adder_accum_stage #(.ACC_W(6), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
    .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  // Reference: packet total from plain arithmetic over the whole beat list.
  function automatic void model(input int vals[$], input int aw, input int cw,
                                output int s, output int c, output int o);
    int total = 0;
    foreach (vals[i]) total += vals[i];
    o = (total >= (1 << aw)) ? 1 : 0;
`ifdef ADDER_ACCUM_SAT_EN
    s = (o != 0) ? (1 << aw) - 1 : total;
`else
    s = total % (1 << aw);
`endif
    c = (vals.size() > (1 << cw) - 1) ? (1 << cw) - 1 : vals.size();
  endfunction

  task automatic drive_beat(input int v, input bit last);
    logic [4:0] b5;
    b5 = v[4:0];
    in_valid = 1'b1;
    {in_cout, in_sum} = b5;
    in_last = last;
  endtask

  // Sends a packet, waits for its result with out_ready=1 and captures both instances.
  task automatic run_packet(input int vals[$], input bit gaps,
                            output int as, output int ac, output int ao,
                            output int bs, output int bc, output int bo,
                            output int lat, output bit tmo);
    int n;
    tmo = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < vals.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last = 1'($urandom_range(0, 1));
        in_sum = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
      end
      drive_beat(vals[i], i == vals.size() - 1);
      n = 0;
      @(negedge clk);
      while (!a_in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) tmo = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!a_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) tmo = 1'b1;
    as = a_out_sum; ac = a_out_count; ao = a_out_ovf;
    bs = b_out_sum; bc = b_out_count; bo = b_out_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_sum = 4'h0; in_cout = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b/%b expected 0/0", a_in_ready, b_in_ready); end
    tests++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", a_out_valid, b_out_valid); end
    tests++; if (a_out_sum !== 12'd0 || a_out_count !== 8'd0 || a_out_ovf !== 1'b0) begin fails++; $display("FAIL reset_outputs: got sum %0d count %0d ovf %b expected 0 0 0", a_out_sum, a_out_count, a_out_ovf); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", a_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat;
    out_ready = 1'b1;
    drive_beat(31, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL single_latency: got out_valid %b expected 1", a_out_valid); end
    tests++; if (a_out_sum !== 12'd31 || a_out_count !== 8'd1 || a_out_ovf !== 1'b0) begin fails++; $display("FAIL single_result: got %0d/%0d/%b expected 31/1/0", a_out_sum, a_out_count, a_out_ovf); end
    tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL single_ready_hold: got %b expected 0", a_in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin fails++; $display("FAIL single_after: got ready %b valid %b expected 1 0", a_in_ready, a_out_valid); end
    tests++; if (a_out_sum !== 12'd31) begin fails++; $display("FAIL single_sum_kept: got %0d expected 31", a_out_sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_three_beat;
    int q[$];
    int as, ac, ao, bs, bc, bo, lat;
    bit tmo;
    q.push_back(5); q.push_back(17); q.push_back(31);
    run_packet(q, 1'b0, as, ac, ao, bs, bc, bo, lat, tmo);
    tests++; if (tmo) begin fails++; $display("FAIL three_timeout: got timeout expected result"); end
    tests++; if (as !== 53 || ac !== 3 || ao !== 0) begin fails++; $display("FAIL three_result: got %0d/%0d/%0d expected 53/3/0", as, ac, ao); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL three_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_overflow;
    int q[$];
    int as, ac, ao, bs, bc, bo, lat;
    int exp_bs;
    bit tmo;
    q.push_back(31); q.push_back(31); q.push_back(10);
`ifdef ADDER_ACCUM_SAT_EN
    exp_bs = 63;
`else
    exp_bs = 8;
`endif
    run_packet(q, 1'b0, as, ac, ao, bs, bc, bo, lat, tmo);
    tests++; if (bs !== exp_bs || bo !== 1 || bc !== 3) begin fails++; $display("FAIL ovf_small: got %0d/%0d/%0d expected %0d/3/1", bs, bc, bo, exp_bs); end
    tests++; if (as !== 72 || ao !== 0) begin fails++; $display("FAIL ovf_wide: got %0d/%0d expected 72/0", as, ao); end
    q.delete(); q.push_back(2);
    run_packet(q, 1'b0, as, ac, ao, bs, bc, bo, lat, tmo);
    tests++; if (bo !== 0 || bs !== 2) begin fails++; $display("FAIL ovf_cleared: got sum %0d ovf %0d expected 2 0", bs, bo); end
  endtask

  task automatic test_backpressure;
    bit ok_stable = 1'b1;
    out_ready = 1'b0;
    drive_beat(7, 1'b1);
    @(posedge clk); #1;
    drive_beat(4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (a_out_valid !== 1'b1 || a_out_sum !== 12'd7 || a_out_count !== 8'd1 || a_in_ready !== 1'b0) ok_stable = 1'b0;
      @(posedge clk); #1;
    end
    tests++; if (!ok_stable) begin fails++; $display("FAIL bp_stable: got unstable outputs expected 7/1 held with in_ready 0"); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got valid %b ready %b expected 0 1", a_out_valid, a_in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    tests++; if (a_out_valid !== 1'b1 || a_out_sum !== 12'd4 || a_out_count !== 8'd1) begin fails++; $display("FAIL bp_next_beat: got valid %b sum %0d count %0d expected 1 4 1", a_out_valid, a_out_sum, a_out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet;
    int q[$];
    int as, ac, ao, bs, bc, bo, lat;
    bit tmo;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_beat(9, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready: got %b/%b expected 0/0", a_in_ready, b_in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    q.push_back(3);
    run_packet(q, 1'b0, as, ac, ao, bs, bc, bo, lat, tmo);
    tests++; if (as !== 3 || ac !== 1 || ao !== 0 || tmo) begin fails++; $display("FAIL rstmid_result: got %0d/%0d/%0d expected 3/1/0", as, ac, ao); end
  endtask

  task automatic test_count_sat;
    int q[$];
    int as, ac, ao, bs, bc, bo, lat;
    bit tmo;
    repeat (5) q.push_back(1);
    run_packet(q, 1'b0, as, ac, ao, bs, bc, bo, lat, tmo);
    tests++; if (bc !== 3 || bs !== 5) begin fails++; $display("FAIL cnt_sat_small: got count %0d sum %0d expected 3 5", bc, bs); end
    tests++; if (ac !== 5 || as !== 5) begin fails++; $display("FAIL cnt_wide: got count %0d sum %0d expected 5 5", ac, as); end
  endtask

  task automatic test_random;
    int q[$];
    int as, ac, ao, bs, bc, bo, lat;
    int es, ec, eo;
    bit tmo;
    for (int p = 0; p < 40; p++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) q.push_back(int'($urandom_range(0, 31)));
      run_packet(q, 1'b1, as, ac, ao, bs, bc, bo, lat, tmo);
      tests++; if (tmo || lat !== 1) begin fails++; $display("FAIL rand_latency pkt %0d: got %0d expected 1", p, lat); end
      model(q, 12, 8, es, ec, eo);
      tests++; if (as !== es || ac !== ec || ao !== eo) begin fails++; $display("FAIL rand_wide pkt %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", p, as, ac, ao, es, ec, eo); end
      model(q, 6, 2, es, ec, eo);
      tests++; if (bs !== es || bc !== ec || bo !== eo) begin fails++; $display("FAIL rand_small pkt %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", p, bs, bc, bo, es, ec, eo); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_three_beat();
    test_overflow();
    test_backpressure();
    test_reset_mid_packet();
    test_count_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
